// File: rtl/core_quant_pack_pkg.sv
// Shared definitions for the quantize-and-pack output stage: op_cfg field
// layout, int8 saturation limits and the controller state encoding.
package core_quant_pack_pkg;

  localparam int CFG_WIDTH       = 41;
  localparam int CFG_SHIFT_LSB   = 0;
  localparam int CFG_BIAS_LSB    = 5;
  localparam int CFG_SCALE_LSB   = 21;
  localparam int CFG_ACC_NUM_LSB = 31;

  localparam int OUT_MIN = -128;
  localparam int OUT_MAX = 127;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/core_quant_pack_quant_unit.sv
// Three-stage requantization pipeline: scale, bias + rounding shift, int8
// saturation. Each sample carries the cfg value it entered with, so cfg
// register updates never touch samples already in flight. flush drops
// everything in the pipe (used on abort).
module core_quant_pack_quant_unit
  import core_quant_pack_pkg::*;
#(
  parameter int ACC_WIDTH   = 24,
  parameter int SCALE_WIDTH = 10,
  parameter int BIAS_WIDTH  = 16,
  parameter int SHIFT_WIDTH = 5,
  parameter int ODATA_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_vld,
  input  logic                   in_last,
  input  logic [ACC_WIDTH-1:0]   acc,
  input  logic [SCALE_WIDTH-1:0] scale,
  input  logic [BIAS_WIDTH-1:0]  bias,
  input  logic [SHIFT_WIDTH-1:0] shift,
  output logic                   out_vld,
  output logic                   out_last,
  output logic [ODATA_WIDTH-1:0] out_data,
  output logic                   out_sat
);

  localparam int PW = ACC_WIDTH + SCALE_WIDTH + 1;
  localparam int SW = PW + 1;
  localparam logic [SHIFT_WIDTH-1:0] SH_ONE = SHIFT_WIDTH'(1);

  logic signed [PW-1:0] acc_x, scale_x, prod_c;
  logic signed [SW-1:0] rnd_c, sum_c, shifted_c;
  logic [ODATA_WIDTH-1:0] sat_data_c;
  logic                   sat_c;

  logic                   s1_vld, s1_last;
  logic signed [PW-1:0]   s1_prod;
  logic [BIAS_WIDTH-1:0]  s1_bias;
  logic [SHIFT_WIDTH-1:0] s1_shift;

  logic                   s2_vld, s2_last;
  logic signed [SW-1:0]   s2_val;

  // S1 operands: signed accumulator times zero-extended unsigned scale.
  always_comb begin
    acc_x   = PW'($signed(acc));
    scale_x = PW'({1'b0, scale});
    prod_c  = acc_x * scale_x;
  end

  // S2 arithmetic: bias, round-half-up term, arithmetic right shift.
  always_comb begin
    rnd_c = '0;
    if (s1_shift != '0) rnd_c = SW'(1) << (s1_shift - SH_ONE);
    sum_c     = SW'(s1_prod) + SW'($signed(s1_bias)) + rnd_c;
    shifted_c = sum_c >>> s1_shift;
  end

  // S3 arithmetic: clip to the int8 range and flag any clipping.
  always_comb begin
    sat_c      = 1'b0;
    sat_data_c = s2_val[ODATA_WIDTH-1:0];
    if (s2_val > SW'(OUT_MAX)) begin
      sat_c      = 1'b1;
      sat_data_c = ODATA_WIDTH'(OUT_MAX);
    end else if (s2_val < SW'(OUT_MIN)) begin
      sat_c      = 1'b1;
      sat_data_c = ODATA_WIDTH'(OUT_MIN);
    end
  end

  // Pipeline registers; valids cleared on reset or flush.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      s1_vld   <= 1'b0;
      s1_last  <= 1'b0;
      s1_prod  <= '0;
      s1_bias  <= '0;
      s1_shift <= '0;
      s2_vld   <= 1'b0;
      s2_last  <= 1'b0;
      s2_val   <= '0;
      out_vld  <= 1'b0;
      out_last <= 1'b0;
      out_data <= '0;
      out_sat  <= 1'b0;
    end else begin
      s1_vld   <= in_vld;
      s1_last  <= in_vld & in_last;
      s1_prod  <= prod_c;
      s1_bias  <= bias;
      s1_shift <= shift;
      s2_vld   <= s1_vld;
      s2_last  <= s1_last;
      s2_val   <= shifted_c;
      out_vld  <= s2_vld;
      out_last <= s2_last;
      out_data <= sat_data_c;
      out_sat  <= s2_vld & sat_c;
    end
  end

endmodule

// File: rtl/core_quant_pack.sv
// Output stage behind the MAC accumulators: requantizes one accumulator per
// cycle to int8, packs MAC_MULT_NUM results per GBUS word and writes them to
// consecutive addresses, then pulses done.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | no operation; waiting for start
// ST_RUN   | accepting acc_in_vld samples until out_num have been taken
// ST_FLUSH | all samples taken; waiting for the final word write, then done
module core_quant_pack
  import core_quant_pack_pkg::*;
#(
  parameter int ACC_WIDTH       = 24,
  parameter int SCALE_WIDTH     = 10,
  parameter int BIAS_WIDTH      = 16,
  parameter int SHIFT_WIDTH     = 5,
  parameter int ODATA_WIDTH     = 8,
  parameter int MAC_MULT_NUM    = 16,
  parameter int GBUS_ADDR_WIDTH = 19,
  parameter int OUT_NUM_WIDTH   = 10
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                op_cfg_vld,
  input  logic [CFG_WIDTH-1:0]                op_cfg,
  input  logic                                start,
  input  logic [GBUS_ADDR_WIDTH-1:0]          start_addr,
  input  logic [OUT_NUM_WIDTH-1:0]            out_num,
  input  logic [ACC_WIDTH-1:0]                acc_in,
  input  logic                                acc_in_vld,
  output logic [GBUS_ADDR_WIDTH-1:0]          out_gbus_addr,
  output logic                                out_gbus_wen,
  output logic [ODATA_WIDTH*MAC_MULT_NUM-1:0] out_gbus_wdata,
  output logic                                busy,
  output logic                                done,
  output logic                                sat_flag
);

  localparam int LANE_W = $clog2(MAC_MULT_NUM);
  localparam int WW     = ODATA_WIDTH * MAC_MULT_NUM;
  localparam logic [LANE_W-1:0] LANE_LAST = LANE_W'(MAC_MULT_NUM - 1);

  state_t state_q, state_d;

  logic [SCALE_WIDTH-1:0]     scale_q;
  logic [BIAS_WIDTH-1:0]      bias_q;
  logic [SHIFT_WIDTH-1:0]     shift_q;
  logic [GBUS_ADDR_WIDTH-1:0] base_q, word_cnt_q;
  logic [OUT_NUM_WIDTH-1:0]   num_q, in_cnt_q, in_cnt_inc;
  logic [LANE_W-1:0]          lane_q;
  logic [WW-1:0]              pack_q, merged;
  logic                       last_wr_q;
  logic                       accept, in_last, done_d, word_end;

  logic                       q_vld, q_last, q_sat;
  logic [ODATA_WIDTH-1:0]     q_data;

  logic unused_acc_num;
  assign unused_acc_num = ^op_cfg[CFG_WIDTH-1:CFG_ACC_NUM_LSB];

  assign in_cnt_inc = in_cnt_q + OUT_NUM_WIDTH'(1);
  assign in_last    = (in_cnt_inc == num_q);
  assign busy       = (state_q != ST_IDLE);

  // Quant cfg registers, loaded by op_cfg_vld.
  always_ff @(posedge clk) begin
    if (rst) begin
      scale_q <= '0;
      bias_q  <= '0;
      shift_q <= '0;
    end else if (op_cfg_vld) begin
      scale_q <= op_cfg[CFG_SCALE_LSB +: SCALE_WIDTH];
      bias_q  <= op_cfg[CFG_BIAS_LSB  +: BIAS_WIDTH];
      shift_q <= op_cfg[CFG_SHIFT_LSB +: SHIFT_WIDTH];
    end
  end

  // Next-state logic; start in any state (re)starts an operation.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (start) begin
          state_d = ST_RUN;
        end else if (acc_in_vld) begin
          accept = 1'b1;
          if (in_last) state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (start) begin
          state_d = ST_RUN;
        end else if (last_wr_q) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Operation bookkeeping: base address, element count, done and sat flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_q   <= '0;
      num_q    <= '0;
      in_cnt_q <= '0;
      done     <= 1'b0;
      sat_flag <= 1'b0;
    end else begin
      done <= done_d;
      if (start) begin
        base_q   <= start_addr;
        num_q    <= (out_num == '0) ? OUT_NUM_WIDTH'(1) : out_num;
        in_cnt_q <= '0;
        sat_flag <= 1'b0;
      end else begin
        if (accept) in_cnt_q <= in_cnt_inc;
        if (q_vld && q_sat) sat_flag <= 1'b1;
      end
    end
  end

  core_quant_pack_quant_unit #(
    .ACC_WIDTH  (ACC_WIDTH),
    .SCALE_WIDTH(SCALE_WIDTH),
    .BIAS_WIDTH (BIAS_WIDTH),
    .SHIFT_WIDTH(SHIFT_WIDTH),
    .ODATA_WIDTH(ODATA_WIDTH)
  ) u_quant (
    .clk     (clk),
    .rst     (rst),
    .flush   (start),
    .in_vld  (accept),
    .in_last (in_last),
    .acc     (acc_in),
    .scale   (scale_q),
    .bias    (bias_q),
    .shift   (shift_q),
    .out_vld (q_vld),
    .out_last(q_last),
    .out_data(q_data),
    .out_sat (q_sat)
  );

  // Current packed word with the arriving element dropped into its lane.
  always_comb begin
    merged = pack_q;
    merged[lane_q*ODATA_WIDTH +: ODATA_WIDTH] = q_data;
  end

  assign word_end = q_last || (lane_q == LANE_LAST);

  // Lane packer and GBUS write port; start discards any partial word.
  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q         <= '0;
      word_cnt_q     <= '0;
      pack_q         <= '0;
      last_wr_q      <= 1'b0;
      out_gbus_wen   <= 1'b0;
      out_gbus_addr  <= '0;
      out_gbus_wdata <= '0;
    end else if (start) begin
      lane_q       <= '0;
      word_cnt_q   <= '0;
      pack_q       <= '0;
      last_wr_q    <= 1'b0;
      out_gbus_wen <= 1'b0;
    end else begin
      out_gbus_wen <= 1'b0;
      last_wr_q    <= 1'b0;
      if (q_vld) begin
        if (word_end) begin
          out_gbus_wen   <= 1'b1;
          out_gbus_wdata <= merged;
          out_gbus_addr  <= base_q + word_cnt_q;
          last_wr_q      <= q_last;
          word_cnt_q     <= word_cnt_q + GBUS_ADDR_WIDTH'(1);
          lane_q         <= '0;
          pack_q         <= '0;
        end else begin
          pack_q <= merged;
          lane_q <= lane_q + LANE_W'(1);
        end
      end
    end
  end

endmodule
